// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Write-side initiator for the integer register file. Two producers share the
// single registered write port rf_wen/rf_wsel/rf_wdat:
//   * the in-order pipeline writeback stream (wb_*), which has no buffering
//     and is held upstream via wb_stall, and
//   * the long-latency (mul/div) result stream (ll_*), which is buffered in a
//     small FIFO so that a result is never lost while the pipeline writes.
//
// The pipeline normally wins. A starvation counter makes sure a buffered
// long-latency result is written after at most STARVE_MAX consecutive
// pipeline wins: at that point wb_stall is raised and the FIFO head is written.
//
// A destination scoreboard (one busy bit per architectural register) records
// long-latency ops that have issued but not yet written back. Decode queries
// it through q_sel1/q_sel2 to detect RAW hazards.
//
// Handshake: the long-latency stream uses valid/ready. A result transfers on
// a rising clk edge where ll_valid && ll_ready are both 1. ll_ready is driven
// from registered state only (FIFO not full), never from ll_valid. The
// producer holds ll_valid/ll_sel/ll_dat stable until the transfer happens.
// The pipeline side is valid/stall: wb_valid with wb_stall=0 on an edge means
// the writeback is consumed; with wb_stall=1 the pipeline holds it.
//
// Ports:
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   wb_valid/sel/dat     pipeline writeback request
//   wb_stall             pipeline must hold its writeback this cycle
//   ll_valid/sel/dat     long-latency result; ll_ready = FIFO can accept
//   rsv_valid/sel        long-latency op issued, reserve its destination
//   q_sel1/2, q_busy1/2  decode hazard query against outstanding reservations
//   sb_err               sticky: reservation of an already-busy register
//   rf_wen/wsel/wdat     registered register-file write port
//
// Optional build macro RF_WRITE_ARBITER_PERF_EN adds two 32-bit counters:
//   perf_stall_cnt       cycles with wb_stall=1
//   perf_ll_wr_cnt       FIFO (long-latency) writes granted
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int XLEN          = 32,
    parameter int REG_ADDR_W    = 5,
    parameter int LL_FIFO_DEPTH = 2,
    parameter int STARVE_MAX    = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    // pipeline writeback
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_sel,
    input  logic [XLEN-1:0]       wb_dat,
    output logic                  wb_stall,
    // long-latency results
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_sel,
    input  logic [XLEN-1:0]       ll_dat,
    // reservation and hazard query
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_sel,
    input  logic [REG_ADDR_W-1:0] q_sel1,
    input  logic [REG_ADDR_W-1:0] q_sel2,
    output logic                  q_busy1,
    output logic                  q_busy2,
    output logic                  sb_err,
    // register file write port
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_wsel,
    output logic [XLEN-1:0]       rf_wdat
`ifdef RF_WRITE_ARBITER_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_ll_wr_cnt
`endif
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int PTR_W    = $clog2(LL_FIFO_DEPTH);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    // -----------------------------------------------------------------------
    // Long-latency FIFO
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    // -----------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] fifo_sel [LL_FIFO_DEPTH];
    logic [XLEN-1:0]       fifo_dat [LL_FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [REG_ADDR_W-1:0] head_sel;
    logic [XLEN-1:0]       head_dat;
    logic                  push;
    logic                  pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_sel   = fifo_sel[rd_ptr[PTR_W-1:0]];
    assign head_dat   = fifo_dat[rd_ptr[PTR_W-1:0]];

    assign ll_ready = !fifo_full;

    // A result for x0 completes the handshake but is never buffered.
    assign push = ll_valid && ll_ready && (ll_sel != '0);

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic                wb_grant;
    logic                ll_grant;
    logic                wb_has_write;

    // Moore: depends only on registered starvation count and FIFO occupancy.
    assign wb_stall = (starve_cnt == STARVE_LIMIT) && !fifo_empty;

    // wb_valid with wb_sel==0 is consumed silently; it does not win the port,
    // so the FIFO head may use that cycle.
    assign wb_has_write = wb_valid && (wb_sel != '0);

    assign wb_grant = !wb_stall && wb_has_write;
    assign ll_grant = !fifo_empty && (wb_stall || !wb_has_write);
    assign pop      = ll_grant;

    // Counts consecutive pipeline wins while a long-latency result waits.
    // Any FIFO write, or an empty FIFO, restarts the count.
    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_empty || ll_grant) begin
            starve_nxt = '0;
        end else if (wb_grant && (starve_cnt != STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Destination scoreboard
    // -----------------------------------------------------------------------
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                rsv_set;

    assign rsv_set = rsv_valid && (rsv_sel != '0);

    // Clear first, then set, so a reservation landing on the same edge as the
    // previous writer's FIFO write keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (ll_grant) begin
            busy_nxt[head_sel] = 1'b0;
        end
        if (rsv_set) begin
            busy_nxt[rsv_sel] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // busy[0] is never set, so an x0 query always returns 0.
    assign q_busy1 = busy[q_sel1];
    assign q_busy2 = busy[q_sel2];

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            sb_err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            starve_cnt <= starve_nxt;
            busy       <= busy_nxt;
            if (rsv_set && busy[rsv_sel]) begin
                sb_err <= 1'b1;
            end
        end
    end

    // FIFO payload needs no reset: entries are only read when the pointers
    // say they hold valid data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sel[wr_ptr[PTR_W-1:0]] <= ll_sel;
            fifo_dat[wr_ptr[PTR_W-1:0]] <= ll_dat;
        end
    end

    // Registered write port: a grant on edge k drives the write for the
    // cycle between edge k and k+1; sel/dat hold when nothing is granted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rf_wen  <= 1'b0;
            rf_wsel <= '0;
            rf_wdat <= '0;
        end else begin
            rf_wen <= wb_grant || ll_grant;
            if (ll_grant) begin
                rf_wsel <= head_sel;
                rf_wdat <= head_dat;
            end else if (wb_grant) begin
                rf_wsel <= wb_sel;
                rf_wdat <= wb_dat;
            end
        end
    end

`ifdef RF_WRITE_ARBITER_PERF_EN
    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_stall_cnt <= '0;
            perf_ll_wr_cnt <= '0;
        end else begin
            if (wb_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (ll_grant) begin
                perf_ll_wr_cnt <= perf_ll_wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed bench for rf_write_arbiter. Every expected register-file write is
// queued as {sel, dat} when the stimulus that causes it is driven; a monitor
// pops and compares on every cycle where rf_wen is 1. Control outputs
// (wb_stall, ll_ready, q_busy*, sb_err) are checked inline.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int W          = REG_ADDR_W + XLEN;

    logic                  clk;
    logic                  nrst;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_sel;
    logic [XLEN-1:0]       wb_dat;
    logic                  wb_stall;
    logic                  ll_valid;
    logic                  ll_ready;
    logic [REG_ADDR_W-1:0] ll_sel;
    logic [XLEN-1:0]       ll_dat;
    logic                  rsv_valid;
    logic [REG_ADDR_W-1:0] rsv_sel;
    logic [REG_ADDR_W-1:0] q_sel1;
    logic [REG_ADDR_W-1:0] q_sel2;
    logic                  q_busy1;
    logic                  q_busy2;
    logic                  sb_err;
    logic                  rf_wen;
    logic [REG_ADDR_W-1:0] rf_wsel;
    logic [XLEN-1:0]       rf_wdat;

    logic [W-1:0] exp_q[$];
    int           checks;
    int           errors;

    rf_write_arbiter #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .LL_FIFO_DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .nrst(nrst),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_dat(wb_dat), .wb_stall(wb_stall),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_sel(ll_sel), .ll_dat(ll_dat),
        .rsv_valid(rsv_valid), .rsv_sel(rsv_sel),
        .q_sel1(q_sel1), .q_sel2(q_sel2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .sb_err(sb_err),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [REG_ADDR_W-1:0] s, input logic [XLEN-1:0] d);
        exp_q.push_back({s, d});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write: unexpected write sel=%0d dat=0x%0h", rf_wsel, rf_wdat);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({rf_wsel, rf_wdat} !== e) begin
                    errors++;
                    $display("FAIL rf_write: got sel=%0d dat=0x%0h expected sel=%0d dat=0x%0h",
                             rf_wsel, rf_wdat, e[W-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        nrst = 1'b0;
        wb_valid = 1'b0; wb_sel = '0; wb_dat = '0;
        ll_valid = 1'b0; ll_sel = '0; ll_dat = '0;
        rsv_valid = 1'b0; rsv_sel = '0;
        q_sel1 = '0; q_sel2 = '0;

        // 1. reset state, then a single pipeline write
        #3;
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_wsel", rf_wsel, 0);
        chk("rst_rf_wdat", rf_wdat, 0);
        chk("rst_ll_ready", ll_ready, 1);
        chk("rst_wb_stall", wb_stall, 0);
        chk("rst_q_busy1", q_busy1, 0);
        chk("rst_q_busy2", q_busy2, 0);
        chk("rst_sb_err", sb_err, 0);
        @(negedge clk);
        nrst = 1'b1;
        wb_valid = 1'b1; wb_sel = 5'd5; wb_dat = 32'hA5;
        push_exp(5'd5, 32'hA5);
        tick();
        wb_valid = 1'b0;
        chk("t1_rf_wen", rf_wen, 1);

        // 2. reservation, hazard query, long-latency write clears busy
        rsv_valid = 1'b1; rsv_sel = 5'd7;
        tick();
        rsv_valid = 1'b0;
        q_sel1 = 5'd7; q_sel2 = 5'd0;
        #1;
        chk("t2_q_busy1_set", q_busy1, 1);
        chk("t2_q_busy2_x0", q_busy2, 0);
        ll_valid = 1'b1; ll_sel = 5'd7; ll_dat = 32'h1234;
        push_exp(5'd7, 32'h1234);
        tick();
        ll_valid = 1'b0;
        chk("t2_q_busy1_pending", q_busy1, 1);
        chk("t2_ll_ready_one", ll_ready, 1);
        tick();
        chk("t2_rf_wen_ll", rf_wen, 1);
        chk("t2_q_busy1_clear", q_busy1, 0);

        // 3. starvation: one buffered entry against a continuous pipeline
        wb_valid = 1'b1; wb_sel = 5'd3; wb_dat = 32'hD0;
        ll_valid = 1'b1; ll_sel = 5'd12; ll_dat = 32'hBEEF;
        push_exp(5'd3, 32'hD0);
        tick();
        ll_valid = 1'b0;
        chk("t3_stall_e1", wb_stall, 0);
        for (int i = 1; i <= 4; i++) begin
            wb_dat = 32'hD0 + XLEN'(i);
            push_exp(5'd3, wb_dat);
            tick();
            chk($sformatf("t3_stall_e%0d", i + 1), wb_stall, (i == 4) ? 1 : 0);
        end
        wb_dat = 32'hD5;
        push_exp(5'd12, 32'hBEEF);
        tick();
        chk("t3_stall_after_ll", wb_stall, 0);
        chk("t3_rf_wsel_ll", rf_wsel, 12);
        push_exp(5'd3, 32'hD5);
        tick();
        wb_valid = 1'b0;
        chk("t3_rf_wsel_resume", rf_wsel, 3);
        chk("t3_stall_resume", wb_stall, 0);

        // 4. full FIFO with a continuous pipeline
        wb_valid = 1'b1; wb_sel = 5'd4; wb_dat = 32'hE0;
        ll_valid = 1'b1; ll_sel = 5'd20; ll_dat = 32'hC000_0000;
        push_exp(5'd4, 32'hE0);
        tick();
        chk("t4_ready_a1", ll_ready, 1);
        wb_dat = 32'hE1; ll_sel = 5'd21; ll_dat = 32'hC000_0001;
        push_exp(5'd4, 32'hE1);
        tick();
        chk("t4_ready_full", ll_ready, 0);
        ll_sel = 5'd22; ll_dat = 32'hC000_0002;
        for (int i = 2; i <= 4; i++) begin
            wb_dat = 32'hE0 + XLEN'(i);
            push_exp(5'd4, wb_dat);
            tick();
            chk($sformatf("t4_ready_held_a%0d", i + 1), ll_ready, 0);
        end
        chk("t4_stall", wb_stall, 1);
        wb_dat = 32'hE5;
        push_exp(5'd20, 32'hC000_0000);
        tick();
        chk("t4_ready_after_pop", ll_ready, 1);
        push_exp(5'd4, 32'hE5);
        tick();
        ll_valid = 1'b0; wb_valid = 1'b0;
        chk("t4_ready_full_again", ll_ready, 0);
        push_exp(5'd21, 32'hC000_0001);
        push_exp(5'd22, 32'hC000_0002);
        tick();
        tick();
        chk("t4_ready_drained", ll_ready, 1);

        // 5. x0 handling and scoreboard errors
        tick();
        wb_valid = 1'b1; wb_sel = 5'd0; wb_dat = 32'hFF;
        tick();
        wb_valid = 1'b0;
        chk("t5_wb_x0_no_write", rf_wen, 0);
        ll_valid = 1'b1; ll_sel = 5'd0; ll_dat = 32'h77;
        tick();
        ll_valid = 1'b0;
        tick();
        chk("t5_ll_x0_no_write", rf_wen, 0);
        rsv_valid = 1'b1; rsv_sel = 5'd9;
        tick();
        chk("t5_sb_err_first", sb_err, 0);
        tick();
        rsv_valid = 1'b0;
        chk("t5_sb_err_set", sb_err, 1);
        tick();
        chk("t5_sb_err_sticky", sb_err, 1);
        ll_valid = 1'b1; ll_sel = 5'd9; ll_dat = 32'h99;
        tick();
        ll_valid = 1'b0;
        rsv_valid = 1'b1; rsv_sel = 5'd9;
        push_exp(5'd9, 32'h99);
        tick();
        rsv_valid = 1'b0;
        q_sel1 = 5'd9;
        #1;
        chk("t5_set_wins", q_busy1, 1);
        chk("t5_sb_err_still", sb_err, 1);

        // 6. reset mid-operation
        wb_valid = 1'b1; wb_sel = 5'd6; wb_dat = 32'hF0;
        ll_valid = 1'b1; ll_sel = 5'd25; ll_dat = 32'hCC0;
        push_exp(5'd6, 32'hF0);
        tick();
        wb_dat = 32'hF1; ll_sel = 5'd26; ll_dat = 32'hCC1;
        rsv_valid = 1'b1; rsv_sel = 5'd15;
        push_exp(5'd6, 32'hF1);
        tick();
        wb_valid = 1'b0; ll_valid = 1'b0; rsv_valid = 1'b0;
        q_sel1 = 5'd15; q_sel2 = 5'd9;
        #1;
        chk("t6_pre_ready_full", ll_ready, 0);
        chk("t6_pre_busy15", q_busy1, 1);
        @(negedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("t6_rst_rf_wen", rf_wen, 0);
        chk("t6_rst_rf_wsel", rf_wsel, 0);
        chk("t6_rst_ll_ready", ll_ready, 1);
        chk("t6_rst_busy15", q_busy1, 0);
        chk("t6_rst_busy9", q_busy2, 0);
        chk("t6_rst_sb_err", sb_err, 0);
        tick();
        tick();
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_no_stale_%0d", i), rf_wen, 0);
        end
        chk("t6_stall_idle", wb_stall, 0);

        @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
